// File: rtl/clock_display_pkg.sv
// Shared types and constants for the clock display path: refresh FSM states,
// time field widths and decimal-point separator positions.
package clock_display_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int HOURS_W    = 5;
    localparam int MINUTES_W  = 6;
    localparam int SECONDS_W  = 6;
    localparam int DP_W       = NUM_DIGITS;

    // Decimal points lit between HH|MM and MM|SS; bit0 is the hours MSD.
    localparam int DP_SEP_HM = 1;
    localparam int DP_SEP_MS = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } refresh_state_t;

    typedef struct packed {
        logic [HOURS_W-1:0]   hours;
        logic [MINUTES_W-1:0] minutes;
        logic [SECONDS_W-1:0] seconds;
        logic [DP_W-1:0]      dp;
    } time_snap_t;

    function automatic logic [DP_W-1:0] blink_dp(input logic [DP_W-1:0] dp, input logic sec_lsb);
        logic [DP_W-1:0] r;
        r            = dp;
        r[DP_SEP_HM] = dp[DP_SEP_HM] | sec_lsb;
        r[DP_SEP_MS] = dp[DP_SEP_MS] | sec_lsb;
        return r;
    endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Ack timeout counter for a handshake master: counts enabled cycles since the
// last clear and pulses expire on the LIMIT-th enabled cycle.
module ack_watchdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/display_refresh_ctrl.sv
// Refresh sequencer in front of the MAX7219 output wrapper: issues config and
// digit writes, holds a time snapshot per transfer. Optional macro
// DISPLAY_REFRESH_BLINK_EN blinks the HH:MM:SS separators from seconds[0].
module display_refresh_ctrl
    import clock_display_pkg::*;
#(
    parameter int CFG_EVERY_N = 60,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [HOURS_W-1:0]   i_hours,
    input  logic [MINUTES_W-1:0] i_minutes,
    input  logic [SECONDS_W-1:0] i_seconds,
    input  logic [DP_W-1:0]      i_dp,
    input  logic                 i_force_cfg,
    input  logic                 i_busy,
    input  logic                 i_ack,
    output logic                 o_stb,
    output logic                 o_write_config,
    output logic [HOURS_W-1:0]   o_hours,
    output logic [MINUTES_W-1:0] o_minutes,
    output logic [SECONDS_W-1:0] o_seconds,
    output logic [DP_W-1:0]      o_dp,
    output logic                 o_active,
    output logic                 o_timeout
);

    // Handshake: o_stb is a one-cycle request qualified by o_write_config and
    // only raised while the wrapper is not busy; the wrapper answers with a
    // one-cycle i_ack at transfer end. The snapshot is frozen from o_stb until
    // the next issue, and one GAP cycle keeps a new o_stb off the ack cycle.

    localparam logic [7:0] CNT_LAST = 8'(CFG_EVERY_N - 1);

    refresh_state_t state;
    time_snap_t     snap;
    time_snap_t     live;
    logic           cfg_pend;
    logic           data_pend;
    logic [7:0]     write_cnt;
    logic           changed;
    logic           expire;

    assign live    = {i_hours, i_minutes, i_seconds, i_dp};
    assign changed = (live != snap);

    ack_watchdog #(
        .LIMIT (ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .clear   (state != ST_WAIT_ACK),
        .enable  ((state == ST_WAIT_ACK) && !i_ack),
        .expire  (expire)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state          <= ST_IDLE;
            snap           <= '0;
            cfg_pend       <= 1'b1;
            data_pend      <= 1'b1;
            write_cnt      <= '0;
            o_stb          <= 1'b0;
            o_write_config <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_stb     <= 1'b0;
            o_timeout <= 1'b0;
            cfg_pend  <= cfg_pend | i_force_cfg;
            data_pend <= data_pend | changed;

            case (state)
                ST_IDLE: begin
                    if ((cfg_pend || data_pend) && !i_busy) begin
                        state          <= ST_ISSUE;
                        o_stb          <= 1'b1;
                        o_write_config <= cfg_pend;
                        if (cfg_pend) begin
                            // A force arriving on the issue edge is a fresh request.
                            cfg_pend <= i_force_cfg;
                        end else begin
                            snap      <= live;
                            data_pend <= 1'b0;
                        end
                    end
                end

                ST_ISSUE: begin
                    state <= ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    if (i_ack) begin
                        state <= ST_GAP;
                        // Only acked digit writes advance the config cadence.
                        if (!o_write_config) begin
                            if (write_cnt == CNT_LAST) begin
                                write_cnt <= '0;
                                cfg_pend  <= 1'b1;
                            end else begin
                                write_cnt <= write_cnt + 8'd1;
                            end
                        end
                    end else if (expire) begin
                        state     <= ST_GAP;
                        o_timeout <= 1'b1;
                        if (o_write_config) begin
                            cfg_pend <= 1'b1;
                        end else begin
                            data_pend <= 1'b1;
                        end
                    end
                end

                ST_GAP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_active  = (state != ST_IDLE);
    assign o_hours   = snap.hours;
    assign o_minutes = snap.minutes;
    assign o_seconds = snap.seconds;

`ifdef DISPLAY_REFRESH_BLINK_EN
    assign o_dp = blink_dp(snap.dp, snap.seconds[0]);
`else
    assign o_dp = snap.dp;
`endif

endmodule

// File: doc/display_refresh_ctrl.md
Name: display_refresh_ctrl

Overview:
- Sequencer directly upstream of the 7-segment output wrapper (MAX7219 path).
- Watches live clock time; decides when to request a config write or a digit write; owns the stb/busy/ack handshake.
- Holds a stable time snapshot on its outputs for the whole transfer.
- Periodically rewrites the MAX7219 config registers and retries writes that are never acknowledged.

Parameters:
- CFG_EVERY_N, 60, digit writes between forced config rewrites (1..255).
- ACK_TIMEOUT, 4096, cycles in WAIT_ACK before abort and retry (>=16).

Ports:
- i_clk  in  1  system clock (~50MHz)
- i_reset_n  in  1  reset: i_reset_n, synchronous, active-low; clock i_clk
- i_hours  in  5  live hours (0..23)
- i_minutes  in  6  live minutes (0..59)
- i_seconds  in  6  live seconds (0..59)
- i_dp  in  6  live decimal-point mask, bit0 = hours MSD
- i_force_cfg  in  1  one-cycle request for a config rewrite
- i_busy  in  1  wrapper busy
- i_ack  in  1  wrapper ack, one-cycle pulse at transfer end
- o_stb  out  1  write request, one-cycle pulse
- o_write_config  out  1  qualifies o_stb: 1 = config, 0 = digits
- o_hours / o_minutes / o_seconds / o_dp  out  5/6/6/6  snapshot presented to the wrapper
- o_active  out  1  high in any state other than IDLE
- o_timeout  out  1  one-cycle pulse when an ack timeout fires

Behaviour:
- Reset values:
  - All outputs 0. Snapshot registers 0.
  - cfg_pend = 1, data_pend = 1, so the first transfers after reset are config, then digits.
  - Write counter 0; timeout counter 0; state IDLE.
- Reset mid-transfer: returns to IDLE with the same reset values. No stb until the cycle after reset is released.
- Change detect:
  - Each cycle, compare {i_hours, i_minutes, i_seconds, i_dp} against the last issued snapshot.
  - Any mismatch sets data_pend.
  - i_force_cfg sets cfg_pend.
  - Requests arriving while a transfer is in flight are latched, never lost.
- State machine:
  - IDLE: if cfg_pend or data_pend and !i_busy, go to ISSUE. cfg_pend has priority.
  - ISSUE (1 cycle):
    - Assert o_stb = 1 and drive o_write_config.
    - For a digit write, load the snapshot from the live inputs in this same cycle; the snapshot is registered, so it appears on the outputs together with o_stb.
    - Clear the serviced pend flag. Go to WAIT_ACK.
  - WAIT_ACK:
    - Snapshot held constant.
    - On i_ack: go to GAP.
    - If the counter reaches ACK_TIMEOUT-1 with no ack: pulse o_timeout, re-set the serviced pend flag, go to GAP.
  - GAP (1 cycle): go to IDLE. Guarantees no stb in the ack cycle, because the wrapper drops a stb that coincides with ack.
- Config cadence:
  - Each completed (acked) digit write increments the write counter.
  - When the counter reaches CFG_EVERY_N: set cfg_pend and clear the counter.
  - Config writes do not count.
- Latency:
  - IDLE with a pending request to o_stb: 2 cycles (IDLE then ISSUE).
  - Input change to o_stb: 3 cycles if idle (detect, IDLE, ISSUE).
- Simultaneous events:
  - Change and force in the same cycle: config goes first, digits next.
  - Ack and timeout in the same cycle: ack wins, no o_timeout.
  - Input change during WAIT_ACK: data_pend is set; the snapshot is unchanged until the next ISSUE.
- Widths: the timeout counter is clog2(ACK_TIMEOUT) bits; the write counter is 8 bits.

Optional Feature:
- Macro: DISPLAY_REFRESH_BLINK_EN.
- Defined:
  - o_dp[1] and o_dp[3] (hour/minute and minute/second separators) = snapshot seconds[0] OR i_dp bit.
  - A seconds change already triggers a digit write, so the separators blink at 0.5 Hz.
- Undefined: o_dp = the i_dp snapshot, unmodified.

Decomposition:
- Shared package `clock_display_pkg`:
  - state encodings (IDLE, ISSUE, WAIT_ACK, GAP)
  - NUM_DIGITS = 6
  - time field widths (5/6/6/6)
  - DP bit indices for the separators
- One sub-module: `ack_watchdog`, the timeout counter with clear/enable and an expire pulse, reusable by other handshake masters.
- Change detector and pend flags stay inline.

Test Plan:
- Reset release with wrapper idle -> o_stb with o_write_config = 1 at cycle 2. After ack + GAP, o_stb with o_write_config = 0 and snapshot 00:00:00.
- Change i_seconds 5 -> 6 while idle -> o_stb exactly 3 cycles later, o_seconds = 6, held until ack. A change to 7 during WAIT_ACK -> second digit write with o_seconds = 7.
- Never assert i_ack -> o_timeout after 4096 cycles in WAIT_ACK. The same write type is reissued after GAP + IDLE.
- 60 acked digit writes with CFG_EVERY_N = 60 -> the next transfer is config. i_force_cfg together with a change -> config issued before digits.
- i_ack then i_force_cfg asserted the cycle after -> o_stb never coincides with i_ack; the next o_stb arrives at ack + 3 cycles or later.
- DISPLAY_REFRESH_BLINK_EN defined, i_dp = 0, seconds 13 -> o_dp = 6'b001010. Seconds 14 -> o_dp = 0.
